// File: rtl/mic1_run_control.sv
`default_nettype none
// ============================================================================
// mic1_run_control : run/step/stop gate for mic1_soc with PC breakpoints
// Rev 1.0
// ============================================================================
module mic1_run_control #(
  parameter int STEP_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_BREAKPOINTS = 2,
  parameter int CYCLE_WIDTH     = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  btn_run,
  input  logic                                  btn_step,
  input  logic                                  btn_stop,
  input  logic [STEP_WIDTH-1:0]                 step_count,
  input  logic [ADDR_WIDTH-1:0]                 pc,
  input  logic                                  pc_valid,
  input  logic [NUM_BREAKPOINTS*ADDR_WIDTH-1:0] bp_addr,
  input  logic [NUM_BREAKPOINTS-1:0]            bp_enable,
  input  logic                                  cycle_clear,
  output logic                                  run,
  output logic                                  led_idle,
  output logic                                  led_run,
  output logic                                  led_halt,
  output logic [1:0]                            state,
  output logic [NUM_BREAKPOINTS-1:0]            bp_hit,
  output logic [CYCLE_WIDTH-1:0]                cycle_count
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_STEP  = 2'd2;
  localparam logic [1:0] c_BREAK = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [STEP_WIDTH-1:0]      step_cnt_q, step_cnt_d;
  logic                       skip_q, skip_d;
  logic                       prev_run_q, prev_step_q;
  logic [NUM_BREAKPOINTS-1:0] bp_hit_q, bp_hit_d;
  logic [CYCLE_WIDTH-1:0]     cycle_q, cycle_d;

  logic                       w_run_edge, w_step_edge, w_any_match;
  logic [NUM_BREAKPOINTS-1:0] w_match;
  logic [STEP_WIDTH-1:0]      w_step_load;

  assign w_run_edge  = btn_run & ~prev_run_q;
  assign w_step_edge = btn_step & ~prev_step_q;
  assign w_step_load = (step_count == '0) ? STEP_WIDTH'(1) : step_count;

  always_comb begin
    w_match = '0;
    for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
      w_match[i] = pc_valid & bp_enable[i] & ~skip_q &
                   (pc == bp_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  assign w_any_match = |w_match;

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    bp_hit_d   = bp_hit_q;
    skip_d     = skip_q;
    // Skip suppresses only the first fetch after resuming from a break.
    if (skip_q && pc_valid) skip_d = 1'b0;
    case (state_q)
      c_IDLE: begin
        if (btn_stop) begin
          state_d = c_IDLE;
        end else if (w_step_edge) begin
          state_d    = c_STEP;
          step_cnt_d = w_step_load;
        end else if (w_run_edge) begin
          state_d = c_RUN;
        end
      end
      c_RUN: begin
        if (btn_stop) begin
          state_d = c_IDLE;
        end else if (w_any_match) begin
          state_d  = c_BREAK;
          bp_hit_d = w_match;
        end
      end
      c_STEP: begin
        step_cnt_d = step_cnt_q - STEP_WIDTH'(1);
        if (btn_stop) begin
          state_d    = c_IDLE;
          step_cnt_d = '0;
        end else if (w_any_match) begin
          state_d  = c_BREAK;
          bp_hit_d = w_match;
        end else if (step_cnt_q == STEP_WIDTH'(1)) begin
          state_d = c_IDLE;
        end
      end
      default: begin
        if (btn_stop) begin
          state_d  = c_IDLE;
          bp_hit_d = '0;
        end else if (w_step_edge) begin
          state_d    = c_STEP;
          step_cnt_d = w_step_load;
          bp_hit_d   = '0;
          skip_d     = 1'b1;
        end else if (w_run_edge) begin
          state_d  = c_RUN;
          bp_hit_d = '0;
          skip_d   = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    cycle_d = cycle_q;
    if (cycle_clear)         cycle_d = '0;
    else if (run && !(&cycle_q)) cycle_d = cycle_q + CYCLE_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= c_IDLE;
      step_cnt_q  <= '0;
      skip_q      <= 1'b0;
      prev_run_q  <= 1'b1;
      prev_step_q <= 1'b1;
      bp_hit_q    <= '0;
      cycle_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      skip_q      <= skip_d;
      prev_run_q  <= btn_run;
      prev_step_q <= btn_step;
      bp_hit_q    <= bp_hit_d;
      cycle_q     <= cycle_d;
    end
  end

  assign run         = (state_q == c_RUN) || (state_q == c_STEP);
  assign led_idle    = (state_q == c_IDLE);
  assign led_run     = run;
  assign led_halt    = (state_q == c_BREAK);
  assign state       = state_q;
  assign bp_hit      = bp_hit_q;
  assign cycle_count = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_mic1_run_control.sv
`default_nettype none
// Directed bench for mic1_run_control (CYCLE_WIDTH=4 to reach saturation quickly).
module tb_mic1_run_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_run, btn_step, btn_stop;
  logic [7:0]  step_count;
  logic [31:0] pc;
  logic        pc_valid;
  logic [63:0] bp_addr;
  logic [1:0]  bp_enable;
  logic        cycle_clear;
  logic        run, led_idle, led_run, led_halt;
  logic [1:0]  state;
  logic [1:0]  bp_hit;
  logic [3:0]  cycle_count;

  int tests = 0;
  int fails = 0;

  mic1_run_control #(
    .STEP_WIDTH(8), .ADDR_WIDTH(32), .NUM_BREAKPOINTS(2), .CYCLE_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_run(btn_run), .btn_step(btn_step),
    .btn_stop(btn_stop), .step_count(step_count), .pc(pc), .pc_valid(pc_valid),
    .bp_addr(bp_addr), .bp_enable(bp_enable), .cycle_clear(cycle_clear),
    .run(run), .led_idle(led_idle), .led_run(led_run), .led_halt(led_halt),
    .state(state), .bp_hit(bp_hit), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_run = 1'b1; btn_step = 1'b0; btn_stop = 1'b0;
    step_count = 8'd1; pc = 32'h0; pc_valid = 1'b0;
    bp_addr = 64'h0; bp_enable = 2'b00; cycle_clear = 1'b0;
    tick(); tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", state); end
    tests++; if (run !== 1'b0) begin fails++; $display("FAIL reset_run got %b exp 0", run); end
    tests++; if ({led_idle, led_run, led_halt} !== 3'b100) begin fails++; $display("FAIL reset_leds got %b exp 100", {led_idle, led_run, led_halt}); end
    tests++; if (bp_hit !== 2'b00 || cycle_count !== 4'd0) begin fails++; $display("FAIL reset_regs got bp_hit=%b cyc=%0d exp 0/0", bp_hit, cycle_count); end
    reset = 1'b0;
    tick(); tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL held_run_no_edge got %0d exp 0", state); end
    btn_run = 1'b0;
    tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL release_run got %0d exp 0", state); end
    btn_run = 1'b1;
    tick();
    btn_run = 1'b0;
    tests++; if (state !== 2'd1 || run !== 1'b1 || led_run !== 1'b1) begin fails++; $display("FAIL run_press got state=%0d run=%b led_run=%b exp 1/1/1", state, run, led_run); end
    btn_stop = 1'b1;
    tick();
    btn_stop = 1'b0;
    tests++; if (state !== 2'd0 || run !== 1'b0) begin fails++; $display("FAIL run_stop got state=%0d run=%b exp 0/0", state, run); end
  endtask

  task automatic do_step(input logic [7:0] cnt, output int n);
    step_count = cnt;
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (run) n++;
      tick();
    end
  endtask

  task automatic test_step();
    int n;
    do_step(8'd3, n);
    tests++; if (n != 3) begin fails++; $display("FAIL step3_cycles got %0d exp 3", n); end
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL step3_end_state got %0d exp 0", state); end
    do_step(8'd0, n);
    tests++; if (n != 1) begin fails++; $display("FAIL step0_cycles got %0d exp 1", n); end
  endtask

  task automatic test_breakpoint();
    bp_addr = {32'h0000_0040, 32'h0000_0040};
    bp_enable = 2'b10;
    pc = 32'h10; pc_valid = 1'b1;
    cycle_clear = 1'b1;
    tick();
    cycle_clear = 1'b0;
    btn_run = 1'b1;
    tick();
    btn_run = 1'b0;
    tick();
    pc = 32'h40;
    tick();
    tests++; if (state !== 2'd3 || run !== 1'b0 || led_halt !== 1'b1) begin fails++; $display("FAIL bp_break got state=%0d run=%b halt=%b exp 3/0/1", state, run, led_halt); end
    tests++; if (bp_hit !== 2'b10) begin fails++; $display("FAIL bp_hit got %b exp 10", bp_hit); end
    tests++; if (cycle_count !== 4'd2) begin fails++; $display("FAIL bp_cycles got %0d exp 2", cycle_count); end
    tick();
    tests++; if (state !== 2'd3 || bp_hit !== 2'b10 || cycle_count !== 4'd2) begin fails++; $display("FAIL bp_hold got state=%0d bp_hit=%b cyc=%0d exp 3/10/2", state, bp_hit, cycle_count); end
  endtask

  task automatic test_resume_skip();
    btn_run = 1'b1;
    tick();
    btn_run = 1'b0;
    tests++; if (state !== 2'd1 || bp_hit !== 2'b00) begin fails++; $display("FAIL resume got state=%0d bp_hit=%b exp 1/00", state, bp_hit); end
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL skip_first_fetch got %0d exp 1", state); end
    pc = 32'h44;
    tick();
    tests++; if (state !== 2'd1) begin fails++; $display("FAIL no_match_44 got %0d exp 1", state); end
    pc = 32'h40;
    tick();
    tests++; if (state !== 2'd3 || bp_hit !== 2'b10) begin fails++; $display("FAIL rebreak got state=%0d bp_hit=%b exp 3/10", state, bp_hit); end
    btn_stop = 1'b1;
    tick();
    btn_stop = 1'b0;
    tests++; if (state !== 2'd0 || bp_hit !== 2'b00) begin fails++; $display("FAIL break_stop got state=%0d bp_hit=%b exp 0/00", state, bp_hit); end
    pc_valid = 1'b0;
    bp_enable = 2'b00;
  endtask

  task automatic test_step_stop();
    int n;
    step_count = 8'd10;
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      if (run) n++;
      if (k == 3) btn_stop = 1'b1;
      tick();
    end
    tests++; if (n != 4) begin fails++; $display("FAIL stop_burst_cycles got %0d exp 4", n); end
    tests++; if (state !== 2'd0 || run !== 1'b0) begin fails++; $display("FAIL stop_burst_state got state=%0d run=%b exp 0/0", state, run); end
    btn_step = 1'b1;
    tick();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL stop_over_step got %0d exp 0", state); end
    btn_stop = 1'b0;
    btn_step = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    step_count = 8'd10;
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (state !== 2'd0 || run !== 1'b0 || cycle_count !== 4'd0) begin fails++; $display("FAIL reset_mid got state=%0d run=%b cyc=%0d exp 0/0/0", state, run, cycle_count); end
    tick();
  endtask

  task automatic test_cycle_saturate();
    btn_run = 1'b1;
    tick();
    btn_run = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    tests++; if (cycle_count !== 4'd15) begin fails++; $display("FAIL cycle_saturate got %0d exp 15", cycle_count); end
    cycle_clear = 1'b1;
    tick();
    cycle_clear = 1'b0;
    tests++; if (cycle_count !== 4'd0 || run !== 1'b1) begin fails++; $display("FAIL cycle_clear got cyc=%0d run=%b exp 0/1", cycle_count, run); end
    tick();
    tests++; if (cycle_count !== 4'd1) begin fails++; $display("FAIL cycle_after_clear got %0d exp 1", cycle_count); end
    btn_stop = 1'b1;
    tick();
    btn_stop = 1'b0;
    tick();
    tests++; if (cycle_count !== 4'd2 || state !== 2'd0) begin fails++; $display("FAIL cycle_frozen_idle got cyc=%0d state=%0d exp 2/0", cycle_count, state); end
  endtask

  initial begin
    test_reset();
    test_step();
    test_breakpoint();
    test_resume_skip();
    test_step_stop();
    test_reset_mid_burst();
    test_cycle_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
